// File: rtl/ibox_issue.sv
// Issue front end for the integer execute box: decode/read stage feeding an
// execute/writeback stage, with bypass from the X writeback into D reads.
module ibox_issue #(
    parameter int MUL_LATENCY = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    output logic [63:0]          ibox_a,
    output logic [63:0]          ibox_b,
    output logic [12:0]          ibox_opcode,
    input  logic [63:0]          ibox_result,
    output logic                 wb_en,
    output logic [4:0]           wb_addr,
    output logic [63:0]          wb_data,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired,
    input  logic [4:0]           dbg_addr,
    output logic [63:0]          dbg_data
);
    // Hold counter holds the number of X cycles remaining after the current one.
    localparam logic [3:0] HOLD_INIT = 4'(MUL_LATENCY - 1);

    logic [63:0]          regs_q [32];
    logic [63:0]          regs_d [32];
    logic                 x_valid_q, x_valid_d;
    logic                 x_illegal_q, x_illegal_d;
    logic                 x_cmov_q, x_cmov_d;
    logic [4:0]           x_dest_q, x_dest_d;
    logic [63:0]          cmov_val_q, cmov_val_d;
    logic [63:0]          ibox_a_q, ibox_a_d;
    logic [63:0]          ibox_b_q, ibox_b_d;
    logic [12:0]          ibox_op_q, ibox_op_d;
    logic [3:0]           hold_q, hold_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [6:0]  func;
    logic [63:0] rd_a, rd_b;
    logic [63:0] dec_a, dec_b;
    logic [12:0] dec_op;
    logic [4:0]  dec_dest;
    logic        dec_illegal, dec_cmov;
    logic        accept, retire;

    assign op   = in_inst[31:26];
    assign ra   = in_inst[25:21];
    assign rb   = in_inst[20:16];
    assign func = in_inst[11:5];
    assign rc   = in_inst[4:0];

    assign retire   = x_valid_q && (hold_q == 4'd0);
    assign in_ready = (hold_q == 4'd0);
    assign accept   = in_valid && in_ready;

    assign wb_en   = retire && !x_illegal_q && (x_dest_q != 5'd31) &&
                     (!x_cmov_q || ibox_result[0]);
    assign wb_addr = x_dest_q;
    assign wb_data = x_cmov_q ? cmov_val_q : ibox_result;
    assign illegal = retire && x_illegal_q;

    assign ibox_a      = ibox_a_q;
    assign ibox_b      = ibox_b_q;
    assign ibox_opcode = ibox_op_q;
    assign retired     = retired_q;
    assign dbg_data    = (dbg_addr == 5'd31) ? 64'd0 : regs_q[dbg_addr];

    // Register reads see this cycle's writeback so dependent issue needs no bubble.
    always_comb begin
        rd_a = regs_q[ra];
        if (wb_en && wb_addr == ra) rd_a = wb_data;
        if (ra == 5'd31) rd_a = 64'd0;
        rd_b = regs_q[rb];
        if (wb_en && wb_addr == rb) rd_b = wb_data;
        if (rb == 5'd31) rd_b = 64'd0;
    end

    always_comb begin
        dec_a       = 64'd0;
        dec_b       = 64'd0;
        dec_op      = 13'd0;
        dec_dest    = 5'd31;
        dec_illegal = 1'b0;
        dec_cmov    = 1'b0;
        if (op >= 6'h10 && op <= 6'h13) begin
            dec_a    = rd_a;
            dec_b    = in_inst[12] ? {56'd0, in_inst[20:13]} : rd_b;
            dec_op   = {op, func};
            dec_dest = rc;
            dec_cmov = (op == 6'h11) && (func inside {7'h14, 7'h16, 7'h24, 7'h26,
                                                      7'h44, 7'h46, 7'h64, 7'h66});
        end else if (op == 6'h08 || op == 6'h09) begin
            dec_a    = {{48{in_inst[15]}}, in_inst[15:0]};
            dec_b    = rd_b;
            dec_op   = {op, 7'h00};
            dec_dest = ra;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    always_comb begin
        regs_d      = regs_q;
        x_valid_d   = x_valid_q;
        x_illegal_d = x_illegal_q;
        x_cmov_d    = x_cmov_q;
        x_dest_d    = x_dest_q;
        cmov_val_d  = cmov_val_q;
        ibox_a_d    = ibox_a_q;
        ibox_b_d    = ibox_b_q;
        ibox_op_d   = ibox_op_q;
        hold_d      = hold_q;
        retired_d   = retired_q;
        if (wb_en) regs_d[wb_addr] = wb_data;
        if (retire) begin
            x_valid_d = 1'b0;
            retired_d = retired_q + CNT_WIDTH'(1);
        end
        if (accept) begin
            x_valid_d   = 1'b1;
            x_illegal_d = dec_illegal;
            x_cmov_d    = dec_cmov;
            x_dest_d    = dec_dest;
            ibox_a_d    = dec_a;
            ibox_b_d    = dec_b;
            ibox_op_d   = dec_op;
            hold_d      = (op == 6'h13) ? HOLD_INIT : 4'd0;
            if (dec_cmov) cmov_val_d = dec_b;
        end else if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 64'd0;
            x_valid_q   <= 1'b0;
            x_illegal_q <= 1'b0;
            x_cmov_q    <= 1'b0;
            x_dest_q    <= 5'd0;
            cmov_val_q  <= 64'd0;
            ibox_a_q    <= 64'd0;
            ibox_b_q    <= 64'd0;
            ibox_op_q   <= 13'd0;
            hold_q      <= 4'd0;
            retired_q   <= '0;
        end else begin
            regs_q      <= regs_d;
            x_valid_q   <= x_valid_d;
            x_illegal_q <= x_illegal_d;
            x_cmov_q    <= x_cmov_d;
            x_dest_q    <= x_dest_d;
            cmov_val_q  <= cmov_val_d;
            ibox_a_q    <= ibox_a_d;
            ibox_b_q    <= ibox_b_d;
            ibox_op_q   <= ibox_op_d;
            hold_q      <= hold_d;
            retired_q   <= retired_d;
        end
    end
endmodule

// File: tb/tb_ibox_issue.sv
// Bench for ibox_issue: directed scenarios plus a randomized instruction stream
// checked against an in-order architectural model of the register file.
module tb_ibox_issue;
    localparam int MUL_LAT = 3;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] ibox_a, ibox_b, ibox_result, wb_data, dbg_data;
    logic [12:0] ibox_opcode;
    logic        wb_en, illegal;
    logic [4:0]  wb_addr, dbg_addr;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;
    logic [63:0] mr [32];

    ibox_issue #(.MUL_LATENCY(MUL_LAT), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .ibox_a(ibox_a), .ibox_b(ibox_b), .ibox_opcode(ibox_opcode),
        .ibox_result(ibox_result), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] op_enc(logic [5:0] op, logic [4:0] ra, logic [4:0] rb,
                                           logic [6:0] fn, logic [4:0] rc);
        return {op, ra, rb, 3'b000, 1'b0, fn, rc};
    endfunction

    function automatic logic [31:0] lit_enc(logic [5:0] op, logic [4:0] ra, logic [7:0] lit,
                                            logic [6:0] fn, logic [4:0] rc);
        return {op, ra, lit, 1'b1, fn, rc};
    endfunction

    function automatic logic [31:0] mem_enc(logic [5:0] op, logic [4:0] ra, logic [4:0] rb,
                                            logic [15:0] disp);
        return {op, ra, rb, disp};
    endfunction

    function automatic bit is_cmov_func(logic [6:0] f);
        case (f)
            7'h14, 7'h16, 7'h24, 7'h26, 7'h44, 7'h46, 7'h64, 7'h66: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rr(logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : mr[r];
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_inst     = 32'd0;
        ibox_result = 64'd0;
        dbg_addr    = 5'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (ibox_a !== 64'd0) begin bad++; $display("FAIL rst_a: got %0h want 0", ibox_a); end
        total++; if (ibox_b !== 64'd0) begin bad++; $display("FAIL rst_b: got %0h want 0", ibox_b); end
        total++; if (ibox_opcode !== 13'd0) begin bad++; $display("FAIL rst_op: got %0h want 0", ibox_opcode); end
        total++; if (wb_en !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rst_wb: wb_en=%0b illegal=%0b want 0", wb_en, illegal); end
        total++; if (retired !== 32'd0) begin bad++; $display("FAIL rst_retired: got %0d want 0", retired); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_addq();
        in_valid = 1'b1; in_inst = 32'h4020B402; ibox_result = 64'd5;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (ibox_a !== 64'd0 || ibox_b !== 64'd5) begin bad++; $display("FAIL addq_ab: got a=%0h b=%0h want 0,5", ibox_a, ibox_b); end
        total++; if (ibox_opcode !== 13'h0820) begin bad++; $display("FAIL addq_op: got %0h want 820", ibox_opcode); end
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 64'd5) begin bad++; $display("FAIL addq_wb: got en=%0b addr=%0d data=%0h want 1,2,5", wb_en, wb_addr, wb_data); end
        @(negedge clk);
        dbg_addr = 5'd2; #1;
        total++; if (retired !== 32'd1) begin bad++; $display("FAIL addq_retired: got %0d want 1", retired); end
        total++; if (dbg_data !== 64'd5 || wb_en !== 1'b0) begin bad++; $display("FAIL addq_r2: got %0h en=%0b want 5,0", dbg_data, wb_en); end
    endtask

    task automatic test_lda_bypass();
        in_valid = 1'b1; in_inst = mem_enc(6'h08, 5'd3, 5'd2, 16'hFFFC); ibox_result = 64'd1;
        @(negedge clk);
        in_inst = op_enc(6'h10, 5'd3, 5'd3, 7'h20, 5'd4);
        #1;
        total++; if (ibox_a !== 64'hFFFF_FFFF_FFFF_FFFC || ibox_b !== 64'd5) begin bad++; $display("FAIL lda_ab: got a=%0h b=%0h want fffffffffffffffc,5", ibox_a, ibox_b); end
        total++; if (ibox_opcode !== 13'h0400 || in_ready !== 1'b1) begin bad++; $display("FAIL lda_op: got %0h rdy=%0b want 400,1", ibox_opcode, in_ready); end
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 64'd1) begin bad++; $display("FAIL lda_wb: got en=%0b addr=%0d data=%0h want 1,3,1", wb_en, wb_addr, wb_data); end
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'd2;
        #1;
        total++; if (ibox_a !== 64'd1 || ibox_b !== 64'd1) begin bad++; $display("FAIL byp_ab: got a=%0h b=%0h want 1,1", ibox_a, ibox_b); end
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 64'd2) begin bad++; $display("FAIL byp_wb: got en=%0b addr=%0d data=%0h want 1,4,2", wb_en, wb_addr, wb_data); end
        @(negedge clk);
        dbg_addr = 5'd4; #1;
        total++; if (dbg_data !== 64'd2) begin bad++; $display("FAIL byp_r4: got %0h want 2", dbg_data); end
    endtask

    task automatic test_mul();
        int pulses = 0;
        in_valid = 1'b1; in_inst = op_enc(6'h13, 5'd2, 5'd2, 7'h20, 5'd5); ibox_result = 64'd25;
        for (int c = 1; c <= MUL_LAT; c++) begin
            @(negedge clk);
            in_inst = lit_enc(6'h10, 5'd5, 8'd1, 7'h20, 5'd6);
            #1;
            if (wb_en === 1'b1) pulses++;
            total++; if (in_ready !== (c == MUL_LAT)) begin bad++; $display("FAIL mul_ready c%0d: got %0b want %0b", c, in_ready, c == MUL_LAT); end
            total++; if (ibox_a !== 64'd5 || ibox_opcode !== 13'h09A0) begin bad++; $display("FAIL mul_hold c%0d: got a=%0h op=%0h want 5,9a0", c, ibox_a, ibox_opcode); end
            if (c == MUL_LAT) begin
                total++; if (wb_en !== 1'b1 || wb_data !== 64'd25 || wb_addr !== 5'd5) begin bad++; $display("FAIL mul_wb: got en=%0b addr=%0d data=%0h want 1,5,19", wb_en, wb_addr, wb_data); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'd26;
        #1;
        total++; if (pulses != 1) begin bad++; $display("FAIL mul_pulses: got %0d want 1", pulses); end
        total++; if (ibox_a !== 64'd25 || ibox_opcode !== 13'h0820 || wb_data !== 64'd26) begin bad++; $display("FAIL mul_next: got a=%0h op=%0h wd=%0h want 19,820,1a", ibox_a, ibox_opcode, wb_data); end
        @(negedge clk);
    endtask

    task automatic test_cmov();
        logic [31:0] r0;
        #1; r0 = retired;
        in_valid = 1'b1; in_inst = op_enc(6'h11, 5'd5, 5'd6, 7'h24, 5'd7);
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'd0;
        #1;
        total++; if (ibox_b !== 64'd26 || wb_en !== 1'b0) begin bad++; $display("FAIL cmov0: got b=%0h en=%0b want 1a,0", ibox_b, wb_en); end
        @(negedge clk);
        dbg_addr = 5'd7; #1;
        total++; if (retired !== r0 + 32'd1 || dbg_data !== 64'd0) begin bad++; $display("FAIL cmov0_ret: got ret=%0d r7=%0h want %0d,0", retired, dbg_data, r0 + 1); end
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'd3;
        #1;
        total++; if (wb_en !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 64'd26) begin bad++; $display("FAIL cmov1: got en=%0b addr=%0d data=%0h want 1,7,1a", wb_en, wb_addr, wb_data); end
        @(negedge clk);
        #1;
        total++; if (dbg_data !== 64'd26) begin bad++; $display("FAIL cmov1_r7: got %0h want 1a", dbg_data); end
    endtask

    task automatic test_illegal();
        logic [31:0] r0;
        #1; r0 = retired;
        in_valid = 1'b1; in_inst = {6'h1A, 26'h0123456};
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'h0000_0000_0000_00FF;
        #1;
        total++; if (illegal !== 1'b1 || wb_en !== 1'b0 || ibox_opcode !== 13'd0) begin bad++; $display("FAIL ill: got ill=%0b en=%0b op=%0h want 1,0,0", illegal, wb_en, ibox_opcode); end
        @(negedge clk);
        #1;
        total++; if (illegal !== 1'b0 || retired !== r0 + 32'd1) begin bad++; $display("FAIL ill_after: got ill=%0b ret=%0d want 0,%0d", illegal, retired, r0 + 1); end
        in_valid = 1'b1; in_inst = lit_enc(6'h10, 5'd1, 8'd5, 7'h20, 5'd31);
        @(negedge clk);
        in_valid = 1'b0; ibox_result = 64'd5;
        #1;
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL r31_wb: got %0b want 0", wb_en); end
        @(negedge clk);
        dbg_addr = 5'd31; #1;
        total++; if (dbg_data !== 64'd0 || retired !== r0 + 32'd2) begin bad++; $display("FAIL r31: got %0h ret=%0d want 0,%0d", dbg_data, retired, r0 + 2); end
    endtask

    task automatic test_reset_mid_hold();
        in_valid = 1'b1; in_inst = op_enc(6'h13, 5'd2, 5'd2, 7'h20, 5'd9); ibox_result = 64'd77;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0; dbg_addr = 5'd2;
        #1;
        total++; if (ibox_a !== 64'd0 || ibox_opcode !== 13'd0 || wb_en !== 1'b0) begin bad++; $display("FAIL rmh_out: got a=%0h op=%0h en=%0b want 0,0,0", ibox_a, ibox_opcode, wb_en); end
        total++; if (dbg_data !== 64'd0 || retired !== 32'd0) begin bad++; $display("FAIL rmh_regs: got r2=%0h ret=%0d want 0,0", dbg_data, retired); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmh_ready: got %0b want 1", in_ready); end
        for (int c = 0; c < MUL_LAT + 1; c++) begin
            @(negedge clk); #1;
            total++; if (wb_en !== 1'b0 || retired !== 32'd0) begin bad++; $display("FAIL rmh_nowb c%0d: got en=%0b ret=%0d want 0,0", c, wb_en, retired); end
        end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [4:0] ra, rb, rc;
        logic [5:0] op;
        int kind;
        ra = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        rb = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        rc = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        kind = $urandom_range(0, 9);
        if (kind < 4) begin
            op = 6'(6'h10 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                return lit_enc(op, ra, 8'($urandom), 7'($urandom), rc);
            return op_enc(op, ra, rb, 7'($urandom), rc);
        end else if (kind < 6) begin
            return op_enc(6'h11, ra, rb, 7'h24 + 7'(($urandom_range(0, 3)) * 2), rc);
        end else if (kind < 8) begin
            return mem_enc($urandom_range(0, 1) == 1 ? 6'h09 : 6'h08, ra, rb, 16'($urandom));
        end
        do op = 6'($urandom_range(0, 63));
        while (op == 6'h08 || op == 6'h09 || (op >= 6'h10 && op <= 6'h13));
        return {op, 26'($urandom)};
    endfunction

    task automatic test_random(input int n);
        int issued = 0, cycles = 0, left = 0, mret = 0;
        bit busy = 0, have = 0, ill = 0, cmv = 0, exp_ready, ret_now, exp_wb;
        logic [31:0] cur;
        logic [63:0] xa, xb, xres, xcv, exp_wd;
        logic [12:0] xop;
        logic [4:0]  xdest;
        logic [5:0]  op;
        do_reset();
        for (int i = 0; i < 32; i++) mr[i] = 64'd0;
        while ((issued < n || busy) && cycles < 5000) begin
            ibox_result = busy ? xres : {$urandom, $urandom};
            if (!have && issued < n) begin cur = gen_inst(); have = 1; end
            in_valid = have && ($urandom_range(0, 4) != 0);
            in_inst  = in_valid ? cur : $urandom;
            dbg_addr = 5'($urandom);
            #1;
            exp_ready = !busy || left == 1;
            ret_now   = busy && left == 1;
            exp_wb    = ret_now && !ill && xdest != 5'd31 && (!cmv || xres[0]);
            exp_wd    = cmv ? xcv : xres;
            total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready: got %0b want %0b", in_ready, exp_ready); end
            total++; if (wb_en !== exp_wb || illegal !== (ret_now && ill)) begin bad++; $display("FAIL rnd_ctl: got en=%0b ill=%0b want %0b,%0b", wb_en, illegal, exp_wb, ret_now && ill); end
            if (exp_wb) begin
                total++; if (wb_addr !== xdest || wb_data !== exp_wd) begin bad++; $display("FAIL rnd_wb: got %0d/%0h want %0d/%0h", wb_addr, wb_data, xdest, exp_wd); end
            end
            if (busy) begin
                total++; if (ibox_opcode !== xop || (!ill && (ibox_a !== xa || ibox_b !== xb))) begin bad++; $display("FAIL rnd_ops: got %0h/%0h/%0h want %0h/%0h/%0h", ibox_a, ibox_b, ibox_opcode, xa, xb, xop); end
            end
            total++; if (retired !== 32'(mret) || dbg_data !== rr(dbg_addr)) begin bad++; $display("FAIL rnd_state: got ret=%0d dbg=%0h want %0d,%0h", retired, dbg_data, mret, rr(dbg_addr)); end
            if (exp_wb) mr[xdest] = exp_wd;
            if (ret_now) begin busy = 0; mret++; end
            else if (busy) left--;
            if (in_valid && exp_ready) begin
                op = cur[31:26]; ill = 0; cmv = 0; xa = 64'd0; xb = 64'd0; xop = 13'd0; xdest = 5'd31;
                if (op >= 6'h10 && op <= 6'h13) begin
                    xa = rr(cur[25:21]);
                    xb = cur[12] ? 64'(cur[20:13]) : rr(cur[20:16]);
                    xop = {op, cur[11:5]}; xdest = cur[4:0];
                    cmv = (op == 6'h11) && is_cmov_func(cur[11:5]);
                end else if (op == 6'h08 || op == 6'h09) begin
                    xa = 64'($signed(cur[15:0])); xb = rr(cur[20:16]);
                    xop = {op, 7'h00}; xdest = cur[25:21];
                end else ill = 1;
                xcv  = xb;
                xres = {$urandom, $urandom};
                left = (op == 6'h13) ? MUL_LAT : 1;
                busy = 1; have = 0; issued++;
            end
            @(negedge clk);
            cycles++;
        end
        total++; if (cycles >= 5000) begin bad++; $display("FAIL rnd_timeout: issued %0d of %0d", issued, n); end
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_inst = 32'd0;
        ibox_result = 64'd0;
        dbg_addr = 5'd0;
        test_reset();
        test_addq();
        test_lda_bypass();
        test_mul();
        test_cmov();
        test_illegal();
        test_reset_mid_hold();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
